// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - Sequential chunk-serial adder/subtractor with accumulate mode
// Processes CHUNK bits per clock over N = WIDTH/CHUNK RUN cycles.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ctrl,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb, work, work_nx, mask;
  logic             op_ctrl, carry;
  logic             accept, last, cin_msb;
  logic [31:0]      sh;
  logic [CHUNK-1:0] a_sl, bx_sl;
  logic [CHUNK:0]   sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = start && (state != RUN);
    last     = (cnt == CW'(N - 1));
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One slice of the ripple: shift the current slice down to bit 0, add, shift back into work.
  always_comb begin
    sh      = 32'(cnt) * CHUNK;
    a_sl    = CHUNK'(opa >> sh);
    bx_sl   = CHUNK'(opb >> sh) ^ {CHUNK{op_ctrl}};
    sum     = {1'b0, a_sl} + {1'b0, bx_sl} + {{CHUNK{1'b0}}, carry};
    cin_msb = sum[CHUNK-1] ^ a_sl[CHUNK-1] ^ bx_sl[CHUNK-1];
    mask    = WIDTH'({CHUNK{1'b1}}) << sh;
    work_nx = (work & ~mask) | (WIDTH'(sum[CHUNK-1:0]) << sh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      op_ctrl <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      work    <= '0;
      s       <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b1;
    end else if (accept) begin
      opa     <= acc_en ? s : a;
      opb     <= b;
      op_ctrl <= ctrl;
      carry   <= ctrl;
      cnt     <= '0;
    end else if (state == RUN) begin
      work  <= work_nx;
      carry <= sum[CHUNK];
      cnt   <= cnt + 1'b1;
      if (last) begin
        s    <= work_nx;
        co   <= sum[CHUNK];
        ovf  <= cin_msb ^ sum[CHUNK];
        zero <= (work_nx == '0);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - Directed self-checking bench for addsub_seq
module tb_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ctrl, acc_en;
  logic [15:0] a, b;
  logic        busy, done, co, ovf, zero;
  logic [15:0] s;

  logic        start2, ctrl2, acc2;
  logic [15:0] a2, b2;
  logic        busy2, done2, co2, ovf2, zero2;
  logic [15:0] s2;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_s;

  logic [15:0] acc_exp_s   [3] = '{16'h4000, 16'h8000, 16'hC000};
  logic        acc_exp_ovf [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .acc_en(acc_en),
    .a(a), .b(b), .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf), .zero(zero)
  );

  addsub_seq #(.WIDTH(16), .CHUNK(16)) dut1c (
    .clk(clk), .rst(rst), .start(start2), .ctrl(ctrl2), .acc_en(acc2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .s(s2), .co(co2), .ovf(ovf2), .zero(zero2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one operation, scrambles the operand ports during RUN, checks timing and results.
  task automatic op(input string tag, input logic c, input logic [15:0] av, input logic [15:0] bv,
                    input logic [15:0] es, input logic eco, input logic eovf);
    @(negedge clk);
    start = 1'b1; ctrl = c; acc_en = 1'b0; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; ctrl = ~c; acc_en = 1'b1; a = ~av; b = ~bv;
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done_low"}, 32'(done), 32'd0);
      chk({tag, " s_hold"}, 32'(s), 32'(last_s));
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_low"}, 32'(busy), 32'd0);
    chk({tag, " s"}, 32'(s), 32'(es));
    chk({tag, " co"}, 32'(co), 32'(eco));
    chk({tag, " ovf"}, 32'(ovf), 32'(eovf));
    chk({tag, " zero"}, 32'(zero), (es == 16'h0) ? 32'd1 : 32'd0);
    acc_en = 1'b0;
    last_s = es;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ctrl = 1'b0; acc_en = 1'b0; a = '0; b = '0;
    start2 = 1'b0; ctrl2 = 1'b0; acc2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst s", 32'(s), 32'd0);
    chk("rst co", 32'(co), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst zero", 32'(zero), 32'd1);
    chk("rst zero2", 32'(zero2), 32'd1);
    rst = 1'b0;
    last_s = 16'h0;

    // Accumulate chain with start held high: DONE goes straight back to RUN.
    start = 1'b1; acc_en = 1'b1; ctrl = 1'b0; a = 16'h1234; b = 16'h4000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("acc busy", 32'(busy), 32'd1);
      repeat (4) @(negedge clk);
      chk("acc done", 32'(done), 32'd1);
      chk("acc s", 32'(s), 32'(acc_exp_s[k]));
      chk("acc ovf", 32'(ovf), 32'(acc_exp_ovf[k]));
    end
    start = 1'b0; acc_en = 1'b0;
    last_s = 16'hC000;

    op("add1", 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);
    op("sub_eq", 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0);
    op("sub_borrow", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);

    // start during RUN must be ignored
    @(negedge clk);
    start = 1'b1; ctrl = 1'b0; a = 16'h1000; b = 16'h0234;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; ctrl = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign done", 32'(done), 32'd1);
    chk("ign s", 32'(s), 32'h1234);
    chk("ign co", 32'(co), 32'd0);

    // reset in RUN cycle 3
    @(negedge clk);
    start = 1'b1; ctrl = 1'b0; a = 16'h2222; b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst s", 32'(s), 32'd0);
    chk("midrst zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst no_done", 32'(done), 32'd0);
    end
    last_s = 16'h0;
    op("after_rst", 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);

    // single-chunk instance
    @(negedge clk);
    start2 = 1'b1; a2 = 16'h00FF; b2 = 16'h0001; ctrl2 = 1'b0; acc2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    chk("n1 busy", 32'(busy2), 32'd1);
    chk("n1 done_low", 32'(done2), 32'd0);
    @(negedge clk);
    chk("n1 done", 32'(done2), 32'd1);
    chk("n1 busy_low", 32'(busy2), 32'd0);
    chk("n1 s", 32'(s2), 32'h0100);
    chk("n1 co", 32'(co2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
